mdu: RTL
========

# mdu

Multiply/divide unit for the pipelined MIPS core, sitting in EX directly downstream of the register file. It consumes the two register-file read operands (after forwarding) and executes mult/multu/div/divu over several cycles into private HI/LO registers. It also performs mthi/mtlo writes and exposes a busy flag that the hazard unit uses to stall mfhi/mflo/mthi/mtlo and further MDU starts.

## Interface
Parameters:
- MULT_CYCLES, 5, cycles busy is held for mult/multu (≥1)
- DIV_CYCLES, 10, cycles busy is held for div/divu (≥1)

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  one clock; reset is synchronous and active-low (asserted when 0)
- Start  input  1  single-cycle request to begin the operation selected by MDOp
- MDOp  input  2  0 mult, 1 multu, 2 div, 3 divu
- A  input  32  rs operand (forwarded register-file read data 1)
- B  input  32  rt operand (forwarded register-file read data 2)
- MTHI  input  1  write A into HI
- MTLO  input  1  write A into LO
- Busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

## Operation
- States: IDLE, RUN. Counter is wide enough for max(MULT_CYCLES, DIV_CYCLES).
- IDLE, reset deasserted, Start=1:
  - Latch MDOp, A, B.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN; Busy=1 from the next cycle.
- RUN: counter decrements each cycle. On the edge where counter==1:
  - HI/LO take the result.
  - Busy clears; return to IDLE.
- Results:
  - mult: {HI,LO} = signed 64-bit product of A and B.
  - multu: {HI,LO} = unsigned 64-bit product of A and B.
  - div/divu: LO = quotient, HI = remainder. Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0, div or divu): the unit still runs the full DIV_CYCLES, and HI/LO stay unchanged at completion.
- MTHI/MTLO in IDLE: register takes A at the edge. Both asserted: both are written.
- Ignored conditions (the hazard unit guarantees these never occur in legal flow):
  - Start, MTHI and MTLO are all ignored while Busy=1.
  - Start with MTHI or MTLO in the same IDLE cycle: Start wins; MTHI/MTLO are ignored.
- HI/LO are read combinationally by the EX-stage result mux for mfhi/mflo. That read is valid only while Busy=0.

## Timing
- Reset values: Busy=0, HI=0, LO=0, state IDLE, counter 0.
- Reset asserted in any cycle, including mid-RUN: all of the above are restored at that edge, and the in-flight result is discarded.
- Start sampled at edge E: Busy=1 for exactly N cycles after E (N = MULT_CYCLES or DIV_CYCLES). New HI/LO and Busy=0 are visible together after edge E+N.
- Back-to-back operations: a new Start is accepted in the first cycle Busy=0, i.e. cycle E+N. Minimum issue interval is N+1 edges from the first Start to the second completion start.
- Operands are latched at E. Changes to A/B during RUN have no effect.
- Start is not stored while busy; there is no queue.
- The hazard unit stalls on (Busy | Start) so that an mf*/mt* immediately following an MDU start is held.

## Test plan
- Reset, then mult A=0xFFFFFFFF B=0x00000002 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Same operands with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7) B=2 -> after 10 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7 B=2 -> LO=3, HI=1. div A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x1234 and LO=0x5678 via MTHI/MTLO, then divu B=0 -> Busy 10 cycles, HI=0x1234, LO=0x5678 unchanged.
- Start a mult; during RUN pulse Start (div), MTHI and MTLO with A=0xDEADBEEF -> all ignored; final HI/LO match the mult result only.
- Start a div; assert reset in the 4th busy cycle -> next cycle Busy=0, HI=0, LO=0. The following Start is accepted normally.
- Start and MTLO asserted in the same IDLE cycle -> LO not written by MTLO; operation completes normally. Back-to-back Start in the first idle cycle after completion -> accepted.

Source files
------------

// File: rtl/mdu_if.sv
// Operand/control bundle between the EX stage and the multiply/divide unit.
// The master drives operations; the slave (the MDU) returns Busy and HI/LO.
interface mdu_if;
  logic        Start;
  logic [1:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        MTHI;
  logic        MTLO;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output Start, MDOp, A, B, MTHI, MTLO,
    input  Busy, HI, LO
  );

  modport slave (
    input  Start, MDOp, A, B, MTHI, MTLO,
    output Busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle MIPS multiply/divide unit with private HI/LO registers.
// Busy is held for a fixed cycle count per operation; results land as Busy drops.
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0]   r_hi, r_lo, w_hi_nxt, w_lo_nxt;
  logic [1:0]    r_op;
  logic [31:0]   r_a, r_b;
  logic          w_accept;

  logic [63:0] w_prod_s, w_prod_u;
  logic        w_neg_a, w_neg_b, w_b_zero;
  logic [31:0] w_mag_a, w_mag_b, w_divisor, w_uq, w_ur, w_div_q, w_div_r;

  assign w_prod_u = {32'b0, r_a} * {32'b0, r_b};
  assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
  assign w_neg_a   = (r_op == 2'd2) & r_a[31];
  assign w_neg_b   = (r_op == 2'd2) & r_b[31];
  assign w_mag_a   = w_neg_a ? -r_a : r_a;
  assign w_mag_b   = w_neg_b ? -r_b : r_b;
  assign w_b_zero  = (r_b == 32'd0);
  assign w_divisor = w_b_zero ? 32'd1 : w_mag_b;
  assign w_uq      = w_mag_a / w_divisor;
  assign w_ur      = w_mag_a % w_divisor;
  assign w_div_q   = (w_neg_a ^ w_neg_b) ? -w_uq : w_uq;
  assign w_div_r   = w_neg_a ? -w_ur : w_ur;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_accept    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.Start) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
          w_cnt_nxt   = bus.MDOp[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else begin
          if (bus.MTHI) w_hi_nxt = bus.A;
          if (bus.MTLO) w_lo_nxt = bus.A;
        end
      end
      RUN: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = IDLE;
          if (!r_op[1]) begin
            {w_hi_nxt, w_lo_nxt} = r_op[0] ? w_prod_u : w_prod_s;
          end else if (!w_b_zero) begin
            w_hi_nxt = w_div_r;
            w_lo_nxt = w_div_q;
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
    end
  end

  // NOTE: operand latches carry no reset; they are only read in RUN, after being loaded.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_op <= bus.MDOp;
      r_a  <= bus.A;
      r_b  <= bus.B;
    end
  end

  assign bus.Busy = (r_state == RUN);
  assign bus.HI   = r_hi;
  assign bus.LO   = r_lo;
endmodule
